// File: rtl/painterengine_gpu_triangle_scanner.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_triangle_scanner
//
// Front end of the triangle rasterizer. It takes one triangle command and
// finds the triangle's bounding box. It clips that box to the render target,
// then walks every pixel of the clipped box in raster order (x fastest). It
// emits one test point per cycle, alongside the latched vertices and colours,
// for the rasterizer to test coverage.
//
// Ports
//   i_wire_clock, i_wire_resetn     clock (rising edge), async active-low reset
//   i_wire_start                    command strobe, sampled only when idle
//   i_wire_point1..3                vertices, {y[15:0], x[15:0]} signed
//   i_wire_yes_color, i_wire_no_color  colours forwarded with the command
//   i_wire_width, i_wire_height     unsigned render-target size
//   i_wire_hold                     downstream stall, only affects scanning
//   o_wire_busy                     command in progress
//   o_wire_done                     one-cycle completion pulse
//   o_wire_valid, o_wire_test_point test point {y, x}, qualified by valid
//   o_wire_point1..3, o_wire_yes_color, o_wire_no_color  latched command
// -----------------------------------------------------------------------------
module painterengine_gpu_triangle_scanner (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_start,
    input  logic [31:0] i_wire_point1,
    input  logic [31:0] i_wire_point2,
    input  logic [31:0] i_wire_point3,
    input  logic [31:0] i_wire_yes_color,
    input  logic [31:0] i_wire_no_color,
    input  logic [15:0] i_wire_width,
    input  logic [15:0] i_wire_height,
    input  logic        i_wire_hold,
    output logic        o_wire_busy,
    output logic        o_wire_done,
    output logic        o_wire_valid,
    output logic [31:0] o_wire_test_point,
    output logic [31:0] o_wire_point1,
    output logic [31:0] o_wire_point2,
    output logic [31:0] o_wire_point3,
    output logic [31:0] o_wire_yes_color,
    output logic [31:0] o_wire_no_color
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BBOX = 3'd1;
    localparam logic [2:0] ST_CLIP = 3'd2;
    localparam logic [2:0] ST_SCAN = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic signed [15:0] smin3(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [15:0] smax3(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    logic [2:0]         state_q, state_d;
    logic [31:0]        p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [31:0]        yes_q, yes_d, no_q, no_d;
    logic [15:0]        width_q, width_d, height_q, height_d;
    logic signed [15:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [15:0] ymin_q, ymin_d, ymax_q, ymax_d;
    // Clipped bounds are non-negative once the box is known to be non-empty,
    // so the scan side keeps them unsigned.
    logic [15:0]        cxmin_q, cxmin_d, cxmax_q, cxmax_d, cymax_q, cymax_d;
    logic [15:0]        x_q, x_d, y_q, y_d;
    logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [31:0]        tp_q, tp_d;

    // 17-bit signed clip arithmetic: width-1 becomes -1 for a zero-size target
    // instead of wrapping to 65535.
    logic signed [16:0] w_m1, h_m1;
    logic signed [16:0] xmin_x, xmax_x, ymin_x, ymax_x;
    logic signed [16:0] clip_xmin, clip_xmax, clip_ymin, clip_ymax;
    logic               clip_empty;

    always_comb begin
        w_m1      = $signed({1'b0, width_q})  - 17'sd1;
        h_m1      = $signed({1'b0, height_q}) - 17'sd1;
        xmin_x    = {xmin_q[15], xmin_q};
        xmax_x    = {xmax_q[15], xmax_q};
        ymin_x    = {ymin_q[15], ymin_q};
        ymax_x    = {ymax_q[15], ymax_q};
        clip_xmin = (xmin_x < 17'sd0) ? 17'sd0 : xmin_x;
        clip_xmax = (xmax_x > w_m1)   ? w_m1   : xmax_x;
        clip_ymin = (ymin_x < 17'sd0) ? 17'sd0 : ymin_x;
        clip_ymax = (ymax_x > h_m1)   ? h_m1   : ymax_x;
        clip_empty = (clip_xmin > clip_xmax) || (clip_ymin > clip_ymax) ||
                     (width_q == 16'd0) || (height_q == 16'd0);
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case statement can leave a latch behind.
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        yes_d    = yes_q;
        no_d     = no_q;
        width_d  = width_q;
        height_d = height_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        cxmin_d  = cxmin_q;
        cxmax_d  = cxmax_q;
        cymax_d  = cymax_q;
        x_d      = x_q;
        y_d      = y_q;
        tp_d     = tp_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        // Busy tracks the state one cycle late on the way down, so it also
        // covers the cycle carrying the done pulse.
        busy_d   = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (i_wire_start) begin
                    p1_d     = i_wire_point1;
                    p2_d     = i_wire_point2;
                    p3_d     = i_wire_point3;
                    yes_d    = i_wire_yes_color;
                    no_d     = i_wire_no_color;
                    width_d  = i_wire_width;
                    height_d = i_wire_height;
                    busy_d   = 1'b1;
                    state_d  = ST_BBOX;
                end
            end
            ST_BBOX: begin
                xmin_d  = smin3(p1_q[15:0],  p2_q[15:0],  p3_q[15:0]);
                xmax_d  = smax3(p1_q[15:0],  p2_q[15:0],  p3_q[15:0]);
                ymin_d  = smin3(p1_q[31:16], p2_q[31:16], p3_q[31:16]);
                ymax_d  = smax3(p1_q[31:16], p2_q[31:16], p3_q[31:16]);
                state_d = ST_CLIP;
            end
            ST_CLIP: begin
                cxmin_d = clip_xmin[15:0];
                cxmax_d = clip_xmax[15:0];
                cymax_d = clip_ymax[15:0];
                x_d     = clip_xmin[15:0];
                y_d     = clip_ymin[15:0];
                state_d = clip_empty ? ST_DONE : ST_SCAN;
            end
            ST_SCAN: begin
                if (!i_wire_hold) begin
                    valid_d = 1'b1;
                    tp_d    = {y_q, x_q};
                    if (x_q < cxmax_q) begin
                        x_d = x_q + 16'd1;
                    end else begin
                        x_d = cxmin_q;
                        y_d = y_q + 16'd1;
                        if (y_q >= cymax_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q  <= ST_IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            width_q  <= '0;
            height_q <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            cxmin_q  <= '0;
            cxmax_q  <= '0;
            cymax_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            tp_q     <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            yes_q    <= yes_d;
            no_q     <= no_d;
            width_q  <= width_d;
            height_q <= height_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            cxmin_q  <= cxmin_d;
            cxmax_q  <= cxmax_d;
            cymax_q  <= cymax_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tp_q     <= tp_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign o_wire_busy       = busy_q;
    assign o_wire_done       = done_q;
    assign o_wire_valid      = valid_q;
    assign o_wire_test_point = tp_q;
    assign o_wire_point1     = p1_q;
    assign o_wire_point2     = p2_q;
    assign o_wire_point3     = p3_q;
    assign o_wire_yes_color  = yes_q;
    assign o_wire_no_color   = no_q;

endmodule

// File: tb/tb_painterengine_gpu_triangle_scanner.sv
// -----------------------------------------------------------------------------
// Directed testbench for painterengine_gpu_triangle_scanner. Each command is
// issued, then observed one sample per cycle on the falling edge. Sample
// index c = 0 is the cycle right after the edge that samples start. Expected
// bounds, latencies and busy lengths are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_painterengine_gpu_triangle_scanner;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] point1, point2, point3, yes_color, no_color;
    logic [15:0] width, height;
    logic        hold;
    logic        busy, done, valid;
    logic [31:0] test_point, opoint1, opoint2, opoint3, oyes, ono;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] got_pts[$];
    int          first_c, done_c, done_n, busy_n;
    logic        finished;

    painterengine_gpu_triangle_scanner dut (
        .i_wire_clock      (clk),
        .i_wire_resetn     (rst_n),
        .i_wire_start      (start),
        .i_wire_point1     (point1),
        .i_wire_point2     (point2),
        .i_wire_point3     (point3),
        .i_wire_yes_color  (yes_color),
        .i_wire_no_color   (no_color),
        .i_wire_width      (width),
        .i_wire_height     (height),
        .i_wire_hold       (hold),
        .o_wire_busy       (busy),
        .o_wire_done       (done),
        .o_wire_valid      (valid),
        .o_wire_test_point (test_point),
        .o_wire_point1     (opoint1),
        .o_wire_point2     (opoint2),
        .o_wire_point3     (opoint3),
        .o_wire_yes_color  (oyes),
        .o_wire_no_color   (ono)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pt(input int x, input int y);
        return {y[15:0], x[15:0]};
    endfunction

    // Issue one command and record everything the DUT emits until busy falls.
    // hold is raised at samples hold_at .. hold_at+hold_len-1 (affecting the
    // following edges); a stray start with a junk vertex is driven at sample
    // glitch_at (use -1 for none).
    task automatic run_cmd(input logic [31:0] p1, input logic [31:0] p2,
                           input logic [31:0] p3, input logic [15:0] w,
                           input logic [15:0] h, input int hold_at,
                           input int hold_len, input int glitch_at);
        @(negedge clk);
        point1 = p1;
        point2 = p2;
        point3 = p3;
        width  = w;
        height = h;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got_pts.delete();
        first_c  = -1;
        done_c   = -1;
        done_n   = 0;
        busy_n   = 0;
        finished = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (valid) begin
                if (first_c < 0) first_c = c;
                got_pts.push_back(test_point);
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_c = c;
            end
            if (done_c >= 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            hold  = (hold_len > 0) && (c >= hold_at) && (c < hold_at + hold_len);
            start = (c == glitch_at);
            if (c == glitch_at) point1 = pt(-100, -100);
        end
        hold  = 1'b0;
        start = 1'b0;
        check("terminated", {31'd0, finished}, 32'd1);
    endtask

    // Compare the recorded run against hand-computed clipped bounds. An empty
    // box is passed as xlo > xhi.
    task automatic check_scan(input string tag, input int xlo, input int xhi,
                              input int ylo, input int yhi, input int exp_first,
                              input int exp_done, input int exp_busy);
        int n;
        int idx;
        n = (xlo > xhi || ylo > yhi) ? 0 : (xhi - xlo + 1) * (yhi - ylo + 1);
        check({tag, "_count"}, got_pts.size(), n);
        check({tag, "_first"}, first_c, exp_first);
        check({tag, "_done"}, done_c, exp_done);
        check({tag, "_done_len"}, done_n, 1);
        check({tag, "_busy_len"}, busy_n, exp_busy);
        idx = 0;
        for (int y = ylo; y <= yhi && n > 0; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                if (idx < got_pts.size())
                    check($sformatf("%s_pt%0d", tag, idx), got_pts[idx], pt(x, y));
                idx++;
            end
        end
    endtask

    initial begin
        int seen;
        logic [31:0] any_out;
        rst_n     = 1'b0;
        start     = 1'b0;
        hold      = 1'b0;
        point1    = '0;
        point2    = '0;
        point3    = '0;
        yes_color = 32'hFF00FF00;
        no_color  = 32'h000000FF;
        width     = 16'd640;
        height    = 16'd480;
        #12;
        any_out = {31'd0, |{busy, done, valid, test_point, opoint1, opoint2,
                            opoint3, oyes, ono}};
        check("reset_outputs", any_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan: box x 0..3, y 0..2.
        run_cmd(pt(0, 0), pt(3, 0), pt(0, 2), 16'd640, 16'd480, 0, 0, -1);
        check_scan("basic", 0, 3, 0, 2, 3, 15, 16);
        check("basic_p2", opoint2, pt(3, 0));
        check("basic_p3", opoint3, pt(0, 2));
        check("basic_yes", oyes, 32'hFF00FF00);
        check("basic_no", ono, 32'h000000FF);

        // Clipping: bbox x -5..2, y -5..3 clips to x 0..2, y 0..3.
        run_cmd(pt(-5, -5), pt(2, -1), pt(1, 3), 16'd640, 16'd480, 0, 0, -1);
        check_scan("clip", 0, 2, 0, 3, 3, 15, 16);

        // Fully off-screen to the right of a 640-wide target.
        run_cmd(pt(700, 10), pt(800, 20), pt(750, 30), 16'd640, 16'd480, 0, 0, -1);
        check_scan("offscreen", 1, 0, 0, 0, -1, 3, 4);

        // Zero-size targets.
        run_cmd(pt(700, 10), pt(800, 20), pt(750, 30), 16'd0, 16'd480, 0, 0, -1);
        check_scan("w0_off", 1, 0, 0, 0, -1, 3, 4);
        run_cmd(pt(0, 0), pt(3, 0), pt(0, 2), 16'd0, 16'd480, 0, 0, -1);
        check_scan("w0", 1, 0, 0, 0, -1, 3, 4);
        run_cmd(pt(0, 0), pt(3, 0), pt(0, 2), 16'd640, 16'd0, 0, 0, -1);
        check_scan("h0", 1, 0, 0, 0, -1, 3, 4);

        // Single coincident point.
        run_cmd(pt(7, 9), pt(7, 9), pt(7, 9), 16'd640, 16'd480, 0, 0, -1);
        check_scan("single", 7, 7, 9, 9, 3, 4, 5);

        // Hold for two edges after the 5th point (seen at sample 7).
        run_cmd(pt(0, 0), pt(3, 0), pt(0, 2), 16'd640, 16'd480, 7, 2, -1);
        check_scan("hold", 0, 3, 0, 2, 3, 17, 18);

        // Stray start with a junk vertex while busy is ignored.
        run_cmd(pt(0, 0), pt(3, 0), pt(0, 2), 16'd640, 16'd480, 0, 0, 5);
        check_scan("gated", 0, 3, 0, 2, 3, 15, 16);
        check("gated_p1", opoint1, pt(0, 0));

        // Reset asserted during the 6th point of a basic scan.
        @(negedge clk);
        point1 = pt(0, 0);
        point2 = pt(3, 0);
        point3 = pt(0, 2);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen < 6; c++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("rst_reach_6th", seen, 6);
        #1 rst_n = 1'b0;
        #1;
        any_out = {31'd0, |{busy, done, valid, test_point, opoint1, opoint2,
                            opoint3, oyes, ono}};
        check("midscan_reset", any_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(pt(0, 0), pt(3, 0), pt(0, 2), 16'd640, 16'd480, 0, 0, -1);
        check_scan("after_rst", 0, 3, 0, 2, 3, 15, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
